vga_timing_gen: RTL and testbench

Raster timing generator that sits directly upstream of the full-screen sprite renderers. Runs on `vga_clk` with an optional pixel clock enable. Produces the pixel coordinates `DrawX`/`DrawY`, the active-video flag `blank`, the VGA sync pulses and frame/line markers. The renderers use `DrawX`/`DrawY` as ROM addresses and register their colour output from `blank`.

---
 rtl/vga_timing_gen_if.sv | 21 ++
 rtl/vga_timing_gen.sv | 119 +++++++++++
 tb/tb_vga_timing_gen.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between the generator and the sprite renderers
interface vga_timing_gen_if;
   logic       clk_en;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       blank;
   logic       hs;
   logic       vs;
   logic       line_start;
   logic       frame_start;

   modport master (
      input  clk_en,
      output DrawX, DrawY, blank, hs, vs, line_start, frame_start
   );

   modport slave (
      output clk_en,
      input  DrawX, DrawY, blank, hs, vs, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with zero-latency decodes
// Optional macro VGA_SYNC_DELAY_EN: delays hs/vs by SYNC_DELAY vga_clk cycles.
module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int SYNC_DELAY = 1
) (
   input  logic             vga_clk,
   input  logic             reset_n,
   vga_timing_gen_if.master vga
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_VISIBLE);
   localparam logic [9:0] V_ACT    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0] hc_q, hc_d;
   logic [9:0] vc_q, vc_d;
   logic       blank_q, blank_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic       line_q, line_d;
   logic       frame_q, frame_d;

   // Decodes look at the next counter values so they land in the same cycle as DrawX/DrawY.
   always_comb begin
      hc_d    = hc_q;
      vc_d    = vc_q;
      line_d  = 1'b0;
      frame_d = 1'b0;
      if (vga.clk_en) begin
         if (hc_q == H_LAST) begin
            hc_d   = '0;
            line_d = 1'b1;
            if (vc_q == V_LAST) begin
               vc_d    = '0;
               frame_d = 1'b1;
            end else begin
               vc_d = vc_q + 10'd1;
            end
         end else begin
            hc_d = hc_q + 10'd1;
         end
      end
      hs_d    = ~((hc_d >= HS_BEG) && (hc_d < HS_END));
      vs_d    = ~((vc_d >= VS_BEG) && (vc_d < VS_END));
      blank_d = (hc_d < H_ACT) && (vc_d < V_ACT);
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         hc_q    <= H_LAST;
         vc_q    <= V_LAST;
         blank_q <= 1'b0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         hc_q    <= hc_d;
         vc_q    <= vc_d;
         blank_q <= blank_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         line_q  <= line_d;
         frame_q <= frame_d;
      end
   end

   assign vga.DrawX       = hc_q;
   assign vga.DrawY       = vc_q;
   assign vga.blank       = blank_q;
   assign vga.line_start  = line_q;
   assign vga.frame_start = frame_q;

`ifdef VGA_SYNC_DELAY_EN
   logic [SYNC_DELAY-1:0] hs_pipe_q;
   logic [SYNC_DELAY-1:0] vs_pipe_q;

   // Free-running on vga_clk so the sync lines track the renderer's registered colour.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         hs_pipe_q <= '1;
         vs_pipe_q <= '1;
      end else begin
         hs_pipe_q[0] <= hs_q;
         vs_pipe_q[0] <= vs_q;
         for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_pipe_q[i] <= hs_pipe_q[i-1];
            vs_pipe_q[i] <= vs_pipe_q[i-1];
         end
      end
   end

   assign vga.hs = hs_pipe_q[SYNC_DELAY-1];
   assign vga.vs = vs_pipe_q[SYNC_DELAY-1];
`else
   logic [2:0] sync_delay_unused;
   assign sync_delay_unused = 3'(SYNC_DELAY);

   assign vga.hs = hs_q;
   assign vga.vs = vs_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a reduced raster
module tb_vga_timing_gen;

   localparam int HV = 16, HF = 4, HSW = 6, HB = 6;
   localparam int VV = 12, VF = 2, VSW = 2, VB = 4;
   localparam int HT = HV + HF + HSW + HB;
   localparam int VT = VV + VF + VSW + VB;
   localparam int SD = 2;

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic       blank;
      logic       hs;
      logic       vs;
      logic       ls;
      logic       fs;
   } exp_t;

   logic vga_clk = 1'b0;
   logic reset_n = 1'b0;

   vga_timing_gen_if vif ();

   vga_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
      .SYNC_DELAY(SD)
   ) dut (
      .vga_clk(vga_clk),
      .reset_n(reset_n),
      .vga    (vif)
   );

   always #5 vga_clk = ~vga_clk;

   int   total = 0;
   int   bad   = 0;
   int   m_x, m_y;
   logic pipe_hs [SD];
   logic pipe_vs [SD];
   exp_t sb_q [$];

   int cyc, ls_seen, fs_seen, hs_low, vs_low, blank_cnt, fs_first, fs_last;

   function automatic logic raw_hs(int x);
      return !(x >= HV + HF && x < HV + HF + HSW);
   endfunction

   function automatic logic raw_vs(int y);
      return !(y >= VV + VF && y < VV + VF + VSW);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_x = HT - 1;
      m_y = VT - 1;
      for (int i = 0; i < SD; i++) begin
         pipe_hs[i] = 1'b1;
         pipe_vs[i] = 1'b1;
      end
      sb_q.delete();
   endtask

   task automatic clear_counts();
      ls_seen = 0; fs_seen = 0; hs_low = 0; vs_low = 0; blank_cnt = 0;
      fs_first = -1; fs_last = -1;
   endtask

   task automatic step(input bit en);
      exp_t e;
      logic prev_hs, prev_vs;
      prev_hs = raw_hs(m_x);
      prev_vs = raw_vs(m_y);
      for (int i = SD - 1; i > 0; i--) begin
         pipe_hs[i] = pipe_hs[i-1];
         pipe_vs[i] = pipe_vs[i-1];
      end
      pipe_hs[0] = prev_hs;
      pipe_vs[0] = prev_vs;
      e.ls = 1'b0;
      e.fs = 1'b0;
      if (en) begin
         if (m_x == HT - 1) begin
            m_x  = 0;
            e.ls = 1'b1;
            if (m_y == VT - 1) begin
               m_y  = 0;
               e.fs = 1'b1;
            end else begin
               m_y++;
            end
         end else begin
            m_x++;
         end
      end
      e.x     = 10'(m_x);
      e.y     = 10'(m_y);
      e.blank = (m_x < HV) && (m_y < VV);
`ifdef VGA_SYNC_DELAY_EN
      e.hs = pipe_hs[SD-1];
      e.vs = pipe_vs[SD-1];
`else
      e.hs = raw_hs(m_x);
      e.vs = raw_vs(m_y);
`endif
      sb_q.push_back(e);
      vif.clk_en = en;
      @(posedge vga_clk);
      #1;
      cyc++;
      e = sb_q.pop_front();
      check("DrawX", 32'(vif.DrawX), 32'(e.x));
      check("DrawY", 32'(vif.DrawY), 32'(e.y));
      check("blank", 32'(vif.blank), 32'(e.blank));
      check("hs", 32'(vif.hs), 32'(e.hs));
      check("vs", 32'(vif.vs), 32'(e.vs));
      check("line_start", 32'(vif.line_start), 32'(e.ls));
      check("frame_start", 32'(vif.frame_start), 32'(e.fs));
      if (vif.line_start === 1'b1) ls_seen++;
      if (vif.hs === 1'b0) hs_low++;
      if (vif.vs === 1'b0) vs_low++;
      if (vif.blank === 1'b1) blank_cnt++;
      if (vif.frame_start === 1'b1) begin
         fs_seen++;
         if (fs_first < 0) fs_first = cyc;
         fs_last = cyc;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_DrawX"}, 32'(vif.DrawX), 32'(HT - 1));
      check({tag, "_DrawY"}, 32'(vif.DrawY), 32'(VT - 1));
      check({tag, "_blank"}, 32'(vif.blank), 32'd0);
      check({tag, "_hs"}, 32'(vif.hs), 32'd1);
      check({tag, "_vs"}, 32'(vif.vs), 32'd1);
      check({tag, "_line_start"}, 32'(vif.line_start), 32'd0);
      check({tag, "_frame_start"}, 32'(vif.frame_start), 32'd0);
   endtask

   initial begin
      int guard;
      cyc = 0;
      clear_counts();
      vif.clk_en = 1'b0;
      reset_n    = 1'b0;
      model_reset();
      #23;
      check_reset_outputs("rst");

      // first enabled edge after release enters (0,0) with both pulses
      @(negedge vga_clk);
      reset_n = 1'b1;
      clear_counts();
      step(1'b1);
      repeat (HT - 1) step(1'b1);
      check("line0_hs_low", 32'(hs_low), 32'(HSW));
      check("line0_blank", 32'(blank_cnt), 32'(HV));
      check("line0_ls", 32'(ls_seen), 32'd1);
      step(1'b1);

      // full frame with clk_en held high
      guard = 0;
      while (!(m_x == HT - 1 && m_y == VT - 1) && guard < 4 * HT * VT) begin
         step(1'b1);
         guard++;
      end
      check("frame_align", 32'(guard < 4 * HT * VT), 32'd1);
      clear_counts();
      repeat (HT * VT + 1) step(1'b1);
      check("frame_fs_count", 32'(fs_seen), 32'd2);
      check("frame_fs_spacing", 32'(fs_last - fs_first), 32'(HT * VT));
      check("frame_ls_count", 32'(ls_seen), 32'(VT + 1));
      check("frame_vs_low", 32'(vs_low), 32'(VSW * HT));

      // alternating clk_en halves the pixel rate
      clear_counts();
      repeat (HT) begin
         step(1'b1);
         step(1'b0);
      end
      check("ce_ls_count", 32'(ls_seen), 32'd1);
      repeat (3) step(1'b0);

      // reset asserted inside hsync, away from any clock edge
      guard = 0;
      while (!(m_x == HV + HF + 2 && m_y == 5) && guard < 4 * HT * VT) begin
         step(1'b1);
         guard++;
      end
      check("midrst_align", 32'(guard < 4 * HT * VT), 32'd1);
      check("midrst_hs_before", 32'(vif.hs), 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge vga_clk);
      reset_n = 1'b1;
      model_reset();
      clear_counts();
      repeat (HT + 4) step(1'b1);
      check("midrst_fs", 32'(fs_seen), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
